// File: rtl/elink_uplink_pkg.sv
// Shared widths and FSM encoding for the elink uplink packer.
package elink_uplink_pkg;
    localparam int FRAME_W   = 76;
    localparam int PKT_BYTES = 10;
    localparam int PAD_W     = 4;
    localparam int SHIFT_W   = FRAME_W + PAD_W;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
endpackage

// File: rtl/uplink_frame_fifo.sv
// Synchronous frame FIFO; a push while full is ignored even if a pop coincides.
module uplink_frame_fifo
    import elink_uplink_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] wdata,
    output logic [FRAME_W-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);
    logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_wr, w_rd;

    assign full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];
    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/elink_uplink_packer.sv
// Buffers 76-bit CAN uplink frames and serialises each as a 10-byte SOP/EOP packet
// on a valid/ready byte stream, counting sent packets and flagging drops.
module elink_uplink_packer
    import elink_uplink_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [7:0]         dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_sop,
    output logic               dout_eop,
    output logic               busy,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               overflow_err,
    input  logic               clear_err
);
    localparam logic [3:0] LAST = 4'(PKT_BYTES - 1);

    state_t               r_state, w_next;
    logic [SHIFT_W-1:0]   r_shift;
    logic [3:0]           r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;
    logic [FRAME_W-1:0]   w_rdata;
    logic                 w_full, w_empty, w_send, w_accept, w_drop;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    uplink_frame_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (din_valid),
        .pop   (r_state == LOAD),
        .wdata (din),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_send   = (r_state == SEND);
    assign w_accept = w_send && dout_ready;
    assign w_drop   = din_valid && w_full;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next = LOAD;
            LOAD:    w_next = SEND;
            SEND:    if (w_accept && r_idx == LAST) w_next = w_empty ? IDLE : LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD) begin
                r_shift <= {{PAD_W{1'b0}}, w_rdata};
                r_idx   <= '0;
            end else if (w_accept) begin
                if (r_idx == LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_shift <= r_shift << 8;
                    r_idx   <= r_idx + 4'd1;
                end
            end
            // A drop in the same cycle as clear_err must remain visible.
            if (w_drop)         r_ovf <= 1'b1;
            else if (clear_err) r_ovf <= 1'b0;
        end
    end

    assign din_ready    = !w_full;
    assign dout_valid   = w_send;
    assign dout         = w_send ? r_shift[SHIFT_W-1 -: 8] : 8'h00;
    assign dout_sop     = w_send && (r_idx == '0);
    assign dout_eop     = w_send && (r_idx == LAST);
    assign busy         = (r_state != IDLE) || (w_count != '0);
    assign frame_cnt    = r_cnt;
    assign overflow_err = r_ovf;
endmodule

// File: tb/tb_elink_uplink_packer.sv
// Directed bench for elink_uplink_packer: single frame, backpressure, burst,
// overflow, reset mid-packet and counter wrap (CNT_W = 4).
module tb_elink_uplink_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic [75:0] din;
    logic        din_valid, din_ready;
    logic [7:0]  dout;
    logic        dout_valid, dout_ready, dout_sop, dout_eop, busy;
    logic [3:0]  frame_cnt;
    logic        overflow_err, clear_err;

    int          nchk = 0;
    int          nerr = 0;
    int          wait0;
    logic [3:0]  exp_cnt = '0;
    logic [7:0]  got [10];
    logic [75:0] fr [6];

    elink_uplink_packer #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy),
        .frame_cnt(frame_cnt), .overflow_err(overflow_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input logic [75:0] f, input int k);
        logic [79:0] s;
        s = {4'b0000, f};
        return s[79-8*k -: 8];
    endfunction

    function automatic logic [75:0] rnd_frame();
        return {$urandom_range(0, 15), $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [75:0] f);
        din = f; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Accept nb bytes of frame f; with bp, randomly stall before each accept.
    task automatic recv(input logic [75:0] f, input int nb, input bit bp);
        for (int k = 0; k < nb; k++) begin
            int w;
            w = 0;
            while (dout_valid !== 1'b1 && w < 50) begin step(); w++; end
            if (k == 0) wait0 = w;
            chk("valid", {31'b0, dout_valid}, 1);
            if (bp)
                for (int s = 0; s < 4 && $urandom_range(0, 1) == 1; s++) begin
                    dout_ready = 1'b0;
                    step();
                    chk("hold_valid", {31'b0, dout_valid}, 1);
                    chk("hold_byte", {24'b0, dout}, {24'b0, pbyte(f, k)});
                end
            got[k] = dout;
            chk("byte", {24'b0, dout}, {24'b0, pbyte(f, k)});
            chk("sop", {31'b0, dout_sop}, {31'b0, k == 0});
            chk("eop", {31'b0, dout_eop}, {31'b0, k == 9});
            dout_ready = 1'b1;
            step();
            if (k == 9) exp_cnt = exp_cnt + 4'd1;
        end
    endtask

    initial begin
        logic [7:0]  hand [10];
        logic [75:0] f1;
        hand = '{8'h0A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h12};
        f1 = 76'hA_1234_5678_9ABC_DEF0_12;
        rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0; clear_err = 1'b0;
        step(); step();
        chk("rst_din_ready", {31'b0, din_ready}, 1);
        chk("rst_dout_valid", {31'b0, dout_valid}, 0);
        chk("rst_dout", {24'b0, dout}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_cnt", {28'b0, frame_cnt}, 0);
        chk("rst_ovf", {31'b0, overflow_err}, 0);
        rst = 1'b0;
        step();

        // Single frame, hand-computed bytes, 2-cycle latency
        dout_ready = 1'b1;
        push(f1);
        recv(f1, 10, 1'b0);
        chk("latency", wait0, 2);
        for (int k = 0; k < 10; k++) chk("hand_byte", {24'b0, got[k]}, {24'b0, hand[k]});
        chk("cnt_single", {28'b0, frame_cnt}, 1);
        chk("idle_busy", {31'b0, busy}, 0);
        chk("idle_dout", {24'b0, dout}, 0);

        // Backpressure
        dout_ready = 1'b0;
        fr[0] = rnd_frame(); fr[1] = rnd_frame();
        push(fr[0]); push(fr[1]);
        recv(fr[0], 10, 1'b1);
        recv(fr[1], 10, 1'b1);
        chk("cnt_bp", {28'b0, frame_cnt}, {28'b0, exp_cnt});

        // Burst of 4 on consecutive cycles
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin fr[i] = rnd_frame(); push(fr[i]); end
        for (int i = 0; i < 4; i++) begin
            recv(fr[i], 10, 1'b0);
            if (i > 0) chk("bubble", wait0, 1);
        end
        chk("cnt_burst", {28'b0, frame_cnt}, {28'b0, exp_cnt});
        chk("ovf_burst", {31'b0, overflow_err}, 0);

        // Overflow: 6 pushes with output stalled, the 6th is dropped
        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin fr[i] = rnd_frame(); push(fr[i]); end
        chk("ovf_set", {31'b0, overflow_err}, 1);
        chk("ovf_din_ready", {31'b0, din_ready}, 0);
        chk("ovf_busy", {31'b0, busy}, 1);
        din = rnd_frame(); din_valid = 1'b1; clear_err = 1'b1;
        step();
        din_valid = 1'b0;
        chk("ovf_set_wins", {31'b0, overflow_err}, 1);
        step();
        clear_err = 1'b0;
        chk("ovf_clear", {31'b0, overflow_err}, 0);
        for (int i = 0; i < 5; i++) recv(fr[i], 10, 1'b0);
        chk("cnt_drain", {28'b0, frame_cnt}, {28'b0, exp_cnt});
        chk("drain_din_ready", {31'b0, din_ready}, 1);
        chk("drain_busy", {31'b0, busy}, 0);

        // Reset after byte 4 with a second frame buffered
        dout_ready = 1'b0;
        fr[0] = rnd_frame(); fr[1] = rnd_frame();
        push(fr[0]); push(fr[1]);
        recv(fr[0], 5, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, dout_valid}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_cnt", {28'b0, frame_cnt}, 0);
        chk("mid_rst_din_ready", {31'b0, din_ready}, 1);
        step();
        rst = 1'b0;
        exp_cnt = '0;
        step(); step(); step();
        chk("post_rst_valid", {31'b0, dout_valid}, 0);
        fr[2] = rnd_frame();
        push(fr[2]);
        recv(fr[2], 10, 1'b0);
        chk("post_rst_cnt", {28'b0, frame_cnt}, 1);

        // 16 more frames: 17 since reset wraps a 4-bit counter to 1
        for (int i = 0; i < 16; i++) begin
            fr[3] = rnd_frame();
            push(fr[3]);
            recv(fr[3], 10, 1'b0);
        end
        chk("wrap", {28'b0, frame_cnt}, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
